scpu_ctrl: RTL and testbench

SCPU_CTRL -- requirements
Module: scpu_ctrl

---
 rtl/scpu_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_scpu_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scpu_ctrl.sv
// rtl/scpu_ctrl.sv - Multi-cycle control FSM for the simple accumulator CPU
module scpu_ctrl #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ir_op,
  input  logic       zero,
  input  logic       in_valid,
  input  logic       out_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_load,
  output logic [1:0] alu_op,
  output logic       acc_src,
  output logic       in_ack,
  output logic       out_valid,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXEC    = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_IO_WAIT = 3'd5,
    S_HALT    = 3'd6,
    S_UNUSED  = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_IN  = 4'h7;
  localparam logic [3:0] OP_OUT = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Final count of a memory access; the 3-bit counter covers latencies 1..8.
  localparam logic [2:0] CNT_LAST = 3'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic       cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);
  assign state    = state_q;

  // State, wait counter and latched opcode; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= 3'd0;
      op_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Next-state sequencing: memory phases wait MEM_LAT cycles, I/O waits on its handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    case (state_q)
      S_FETCH: begin
        if (cnt_last) begin
          cnt_d   = 3'd0;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DECODE: begin
        op_d = ir_op;
        case (ir_op)
          OP_LDA, OP_ADD, OP_SUB: state_d = S_MEM;
          OP_STA:                 state_d = S_EXEC;
          OP_IN, OP_OUT:          state_d = S_IO_WAIT;
          OP_HLT:                 state_d = S_HALT;
          default:                state_d = S_FETCH;
        endcase
      end
      S_EXEC: state_d = S_FETCH;
      S_MEM: begin
        if (cnt_last) begin
          cnt_d   = 3'd0;
          state_d = S_WB;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WB: state_d = S_FETCH;
      S_IO_WAIT: begin
        if (op_q == OP_IN) begin
          if (in_valid) state_d = S_FETCH;
        end else begin
          if (out_ready) state_d = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_FETCH;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Output decode; everything is forced low while reset is held, even though state reads FETCH.
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    addr_sel  = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    acc_load  = 1'b0;
    alu_op    = 2'b00;
    acc_src   = 1'b0;
    in_ack    = 1'b0;
    out_valid = 1'b0;
    out_load  = 1'b0;
    halted    = 1'b0;
    if (rst) begin
      case (state_q)
        S_FETCH: begin
          mem_rd  = 1'b1;
          ir_load = cnt_last;
          pc_inc  = cnt_last;
        end
        S_DECODE: begin
          // The branch decision uses the freshly loaded IR, not the latched op.
          if (ir_op == OP_JMP) pc_load = 1'b1;
          else if (ir_op == OP_JZ) pc_load = zero;
        end
        S_EXEC: begin
          mem_wr   = 1'b1;
          addr_sel = 1'b1;
        end
        S_MEM: begin
          mem_rd   = 1'b1;
          addr_sel = 1'b1;
        end
        S_WB: begin
          acc_load = 1'b1;
          case (op_q)
            OP_ADD:  alu_op = 2'b01;
            OP_SUB:  alu_op = 2'b10;
            default: alu_op = 2'b00;
          endcase
        end
        S_IO_WAIT: begin
          if (op_q == OP_IN) begin
            acc_src  = 1'b1;
            in_ack   = in_valid;
            acc_load = in_valid;
          end else begin
            out_valid = 1'b1;
            out_load  = out_ready;
          end
        end
        S_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scpu_ctrl.sv
// tb/tb_scpu_ctrl.sv - Trace-checking bench for scpu_ctrl at MEM_LAT 1 and 3
module tb_scpu_ctrl;

  typedef struct packed {
    logic       mem_rd;
    logic       mem_wr;
    logic       addr_sel;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic       acc_load;
    logic [1:0] alu_op;
    logic       acc_src;
    logic       in_ack;
    logic       out_valid;
    logic       out_load;
    logic       halted;
    logic [2:0] state;
  } outs_t;

  typedef struct {
    logic [3:0] op;
    logic       zero;
    logic       in_valid;
    logic       out_ready;
    outs_t      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: MEM_LAT=1
  logic [3:0] a_op = 4'h0;
  logic a_zero = 1'b0, a_iv = 1'b0, a_or = 1'b0;
  logic a_mem_rd, a_mem_wr, a_addr_sel, a_ir_load, a_pc_inc, a_pc_load, a_acc_load;
  logic [1:0] a_alu_op;
  logic a_acc_src, a_in_ack, a_out_valid, a_out_load, a_halted;
  logic [2:0] a_state;

  // Instance B: MEM_LAT=3
  logic [3:0] b_op = 4'h0;
  logic b_zero = 1'b0, b_iv = 1'b0, b_or = 1'b0;
  logic b_mem_rd, b_mem_wr, b_addr_sel, b_ir_load, b_pc_inc, b_pc_load, b_acc_load;
  logic [1:0] b_alu_op;
  logic b_acc_src, b_in_ack, b_out_valid, b_out_load, b_halted;
  logic [2:0] b_state;

  scpu_ctrl #(.MEM_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .ir_op(a_op), .zero(a_zero), .in_valid(a_iv), .out_ready(a_or),
    .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .addr_sel(a_addr_sel), .ir_load(a_ir_load),
    .pc_inc(a_pc_inc), .pc_load(a_pc_load), .acc_load(a_acc_load), .alu_op(a_alu_op),
    .acc_src(a_acc_src), .in_ack(a_in_ack), .out_valid(a_out_valid), .out_load(a_out_load),
    .halted(a_halted), .state(a_state)
  );

  scpu_ctrl #(.MEM_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .ir_op(b_op), .zero(b_zero), .in_valid(b_iv), .out_ready(b_or),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .addr_sel(b_addr_sel), .ir_load(b_ir_load),
    .pc_inc(b_pc_inc), .pc_load(b_pc_load), .acc_load(b_acc_load), .alu_op(b_alu_op),
    .acc_src(b_acc_src), .in_ack(b_in_ack), .out_valid(b_out_valid), .out_load(b_out_load),
    .halted(b_halted), .state(b_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vq[$];

  // Observations gathered during the last trace run
  int acc_cyc[$];
  int ov_first;
  int ir_first;
  int in_ack_n;
  int io_wait_n;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t mk(input logic [2:0] st);
    outs_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  function automatic outs_t get_out(input int sel);
    outs_t o;
    if (sel == 0)
      o = {a_mem_rd, a_mem_wr, a_addr_sel, a_ir_load, a_pc_inc, a_pc_load, a_acc_load,
           a_alu_op, a_acc_src, a_in_ack, a_out_valid, a_out_load, a_halted, a_state};
    else
      o = {b_mem_rd, b_mem_wr, b_addr_sel, b_ir_load, b_pc_inc, b_pc_load, b_acc_load,
           b_alu_op, b_acc_src, b_in_ack, b_out_valid, b_out_load, b_halted, b_state};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic z, input logic iv,
                     input logic ordy, input outs_t e);
    vec_t v;
    v.op = op; v.zero = z; v.in_valid = iv; v.out_ready = ordy; v.exp = e;
    vq.push_back(v);
  endtask

  // Expand one instruction into its expected per-cycle behaviour.
  task automatic push_instr(input int lat, input logic [3:0] op, input logic z,
                            input int wait_n, input bit accept, input int halt_n);
    outs_t e;
    for (int i = 0; i < lat; i++) begin
      e = mk(3'd0);
      e.mem_rd = 1'b1;
      e.ir_load = (i == lat - 1);
      e.pc_inc = (i == lat - 1);
      add(op, rb(), rb(), rb(), e);
    end
    e = mk(3'd1);
    e.pc_load = (op == 4'h5) || (op == 4'h6 && z);
    add(op, z, rb(), rb(), e);
    case (op)
      4'h1, 4'h3, 4'h4: begin
        for (int i = 0; i < lat; i++) begin
          e = mk(3'd3);
          e.mem_rd = 1'b1;
          e.addr_sel = 1'b1;
          add(op, rb(), rb(), rb(), e);
        end
        e = mk(3'd4);
        e.acc_load = 1'b1;
        e.alu_op = (op == 4'h3) ? 2'b01 : (op == 4'h4) ? 2'b10 : 2'b00;
        add(op, rb(), rb(), rb(), e);
      end
      4'h2: begin
        e = mk(3'd2);
        e.mem_wr = 1'b1;
        e.addr_sel = 1'b1;
        add(op, rb(), rb(), rb(), e);
      end
      4'h7: begin
        for (int i = 0; i < wait_n; i++) begin
          e = mk(3'd5);
          e.acc_src = 1'b1;
          add(op, rb(), 1'b0, rb(), e);
        end
        if (accept) begin
          e = mk(3'd5);
          e.acc_src = 1'b1;
          e.in_ack = 1'b1;
          e.acc_load = 1'b1;
          add(op, rb(), 1'b1, rb(), e);
        end
      end
      4'h8: begin
        for (int i = 0; i < wait_n; i++) begin
          e = mk(3'd5);
          e.out_valid = 1'b1;
          add(op, rb(), rb(), 1'b0, e);
        end
        if (accept) begin
          e = mk(3'd5);
          e.out_valid = 1'b1;
          e.out_load = 1'b1;
          add(op, rb(), rb(), 1'b1, e);
        end
      end
      4'hF: begin
        for (int i = 0; i < halt_n; i++) begin
          e = mk(3'd6);
          e.halted = 1'b1;
          add(op, rb(), rb(), rb(), e);
        end
      end
      default: ;
    endcase
  endtask

  task automatic drive(input int sel, input vec_t v);
    if (sel == 0) begin
      a_op = v.op; a_zero = v.zero; a_iv = v.in_valid; a_or = v.out_ready;
    end else begin
      b_op = v.op; b_zero = v.zero; b_iv = v.in_valid; b_or = v.out_ready;
    end
  endtask

  // Assert reset, check both instances are quiet, then release just after a rising edge.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("reset_a", 32'(get_out(0)), 32'(outs_t'('0)));
    check("reset_b", 32'(get_out(1)), 32'(outs_t'('0)));
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Apply the queued vectors cycle by cycle, sampling on the falling edge.
  task automatic run_vecs(input int sel, input string tag);
    outs_t got;
    acc_cyc.delete();
    ov_first = -1; ir_first = -1; in_ack_n = 0; io_wait_n = 0;
    for (int i = 0; i < vq.size(); i++) begin
      drive(sel, vq[i]);
      @(negedge clk);
      got = get_out(sel);
      check($sformatf("%s[%0d]", tag, i), 32'(got), 32'(vq[i].exp));
      if (got.acc_load) acc_cyc.push_back(i);
      if (got.out_valid && ov_first < 0) ov_first = i;
      if (got.ir_load && ir_first < 0) ir_first = i;
      if (got.in_ack) in_ack_n++;
      if (got.state == 3'd5 && !got.in_ack) io_wait_n++;
      @(posedge clk);
      #1;
    end
    vq.delete();
  endtask

  initial begin
    outs_t o;

    // LDA, ADD, OUT at MEM_LAT=1 with the sink always ready
    push_instr(1, 4'h1, 1'b0, 0, 1, 0);
    push_instr(1, 4'h3, 1'b0, 0, 1, 0);
    push_instr(1, 4'h8, 1'b0, 0, 1, 0);
    push_instr(1, 4'h0, 1'b0, 0, 1, 0);
    do_reset();
    run_vecs(0, "lda_add_out");
    check("acc_load_count", 32'(acc_cyc.size()), 32'd2);
    if (acc_cyc.size() == 2) begin
      check("acc_load_cyc0", 32'(acc_cyc[0]), 32'd3);
      check("acc_load_cyc1", 32'(acc_cyc[1]), 32'd7);
    end
    check("out_valid_cyc", 32'(ov_first), 32'd10);

    // MEM_LAT=3 fetch, then a store
    push_instr(3, 4'h0, 1'b0, 0, 1, 0);
    push_instr(3, 4'h2, 1'b0, 0, 1, 0);
    push_instr(3, 4'h0, 1'b0, 0, 1, 0);
    do_reset();
    run_vecs(1, "fetch3_sta");
    check("ir_load_first_cyc", 32'(ir_first), 32'd2);

    // Conditional and unconditional jumps
    push_instr(1, 4'h6, 1'b0, 0, 1, 0);
    push_instr(1, 4'h6, 1'b1, 0, 1, 0);
    push_instr(1, 4'h5, 1'b0, 0, 1, 0);
    push_instr(1, 4'h0, 1'b1, 0, 1, 0);
    do_reset();
    run_vecs(0, "jz_jmp");

    // IN with the source idle for 5 cycles
    push_instr(1, 4'h7, 1'b0, 5, 1, 0);
    push_instr(1, 4'h0, 1'b0, 0, 1, 0);
    do_reset();
    run_vecs(0, "in_wait");
    check("in_ack_count", 32'(in_ack_n), 32'd1);
    check("in_wait_cycles", 32'(io_wait_n), 32'd5);

    // OUT stalled, then reset dropped mid-wait
    push_instr(1, 4'h8, 1'b0, 3, 0, 0);
    do_reset();
    run_vecs(0, "out_stall");
    #1;
    o = get_out(0);
    check("out_valid_holds", 32'(o.out_valid), 32'd1);
    rst = 1'b0;
    #1;
    o = get_out(0);
    check("out_valid_async_drop", 32'(o.out_valid), 32'd0);
    check("state_async_fetch", 32'(o.state), 32'd0);
    @(posedge clk);
    #1;
    check("reset_held_quiet", 32'(get_out(0)), 32'(outs_t'('0)));
    rst = 1'b1;
    push_instr(1, 4'h0, 1'b0, 0, 1, 0);
    run_vecs(0, "after_reset");

    // Illegal opcode B behaves as NOP, then HLT parks for 20 cycles
    push_instr(1, 4'hB, 1'b0, 0, 1, 0);
    push_instr(1, 4'hF, 1'b0, 0, 1, 20);
    do_reset();
    run_vecs(0, "nop_b_halt");

    // Randomized programs on both latencies
    for (int s = 0; s < 2; s++) begin
      int lat;
      lat = (s == 0) ? 1 : 3;
      for (int n = 0; n < 40; n++)
        push_instr(lat, 4'($urandom_range(0, 14)), rb(), int'($urandom_range(0, 4)), 1, 0);
      push_instr(lat, 4'hF, 1'b0, 0, 1, 3);
      do_reset();
      run_vecs(s, (s == 0) ? "rand_lat1" : "rand_lat3");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
